nco_twiddle: RTL and testbench

//   Streaming NCO that produces the complex rotation operand (cos, sin) for the complex multiplier.

---
 rtl/nco_twiddle_pkg.sv | 34 +++
 rtl/nco_twiddle_if.sv | 35 +++
 rtl/nco_twiddle_rom.sv | 43 ++++
 rtl/nco_twiddle.sv | 165 ++++++++++++++++
 tb/tb_nco_twiddle.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/nco_twiddle_pkg.sv
// -----------------------------------------------------------------------------
// nco_twiddle_pkg
//   Shared definitions for the twiddle NCO:
//     - default quarter-wave ROM geometry and full-scale amplitude
//     - quadrant type carried down the pipeline
//     - rom_entry(): constant function that builds the quarter-wave cosine
//       table C[k] = round(AMP * cos(2*pi*(k+0.5)/(4N))) at elaboration.
//   No ports (package).
// -----------------------------------------------------------------------------
package nco_twiddle_pkg;

    localparam int  LUT_AW_DEF    = 10;
    localparam int  LUT_DEPTH_DEF = 1 << LUT_AW_DEF;
    localparam int  AMP_DEF       = 16383;
    localparam real NCO_PI        = 3.14159265358979323846;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // The half-sample offset makes the table an exact mirror: C[N-1-k] is the
    // sine of the same angle as C[k], so one table covers both outputs.
    // Every entry lies in the first quadrant, so the value is never negative
    // and a plain +0.5 truncation is round-to-nearest.
    function automatic int rom_entry(input int k, input int lut_aw, input int amp);
        real theta;
        theta = 2.0 * NCO_PI * ($itor(k) + 0.5) / $itor(4 << lut_aw);
        return $rtoi($itor(amp) * $cos(theta) + 0.5);
    endfunction

endpackage

// File: rtl/nco_twiddle_if.sv
// -----------------------------------------------------------------------------
// nco_twiddle_if
//   Configuration / sample bus of the twiddle NCO.
//     cfg_pinc, cfg_poff  phase increment and offset (unsigned, modulo 2^PHASE_WIDTH)
//     cfg_load            capture cfg_* into the shadow registers
//     sync                phase restart (shadow -> active, accumulator -> 0)
//     in_valid            advance phase and emit one sample
//     out_valid           out_cos / out_sin carry a new sample
//     out_cos, out_sin    signed rotation operand, Q1.14 for the defaults
//   master: sample producer side (drives cfg/sync/in_valid)
//   slave : the NCO itself
// -----------------------------------------------------------------------------
interface nco_twiddle_if #(
    parameter int PHASE_WIDTH = 24,
    parameter int OUT_WIDTH   = 16
);
    logic [PHASE_WIDTH-1:0]      cfg_pinc;
    logic [PHASE_WIDTH-1:0]      cfg_poff;
    logic                        cfg_load;
    logic                        sync;
    logic                        in_valid;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_cos;
    logic signed [OUT_WIDTH-1:0] out_sin;

    modport master (
        output cfg_pinc, cfg_poff, cfg_load, sync, in_valid,
        input  out_valid, out_cos, out_sin
    );

    modport slave (
        input  cfg_pinc, cfg_poff, cfg_load, sync, in_valid,
        output out_valid, out_cos, out_sin
    );
endinterface

// File: rtl/nco_twiddle_rom.sv
// -----------------------------------------------------------------------------
// nco_twiddle_rom
//   Quarter-wave cosine magnitude ROM, N = 2^LUT_AW entries of OUT_WIDTH-1
//   unsigned bits, two independent read ports with one-cycle registered output.
//   Ports:
//     clk                  clock
//     addr_a_i, addr_b_i   read addresses
//     data_a_o, data_b_o   registered magnitudes C[addr], valid one cycle later
// -----------------------------------------------------------------------------
module nco_twiddle_rom
    import nco_twiddle_pkg::*;
#(
    parameter int LUT_AW    = LUT_AW_DEF,
    parameter int OUT_WIDTH = 16,
    parameter int AMP       = AMP_DEF
) (
    input  logic                 clk,
    input  logic [LUT_AW-1:0]    addr_a_i,
    input  logic [LUT_AW-1:0]    addr_b_i,
    output logic [OUT_WIDTH-2:0] data_a_o,
    output logic [OUT_WIDTH-2:0] data_b_o
);
    localparam int DEPTH = 1 << LUT_AW;
    localparam int MAG_W = OUT_WIDTH - 1;

    logic [MAG_W-1:0] rom_w [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom_w[k] = MAG_W'(rom_entry(k, LUT_AW, AMP));
    end

    logic [MAG_W-1:0] data_a_q;
    logic [MAG_W-1:0] data_b_q;

    always_ff @(posedge clk) begin
        data_a_q <= rom_w[addr_a_i];
        data_b_q <= rom_w[addr_b_i];
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/nco_twiddle.sv
// -----------------------------------------------------------------------------
// nco_twiddle
//   Streaming NCO producing the (cos, sin) rotation operand for the complex
//   multiplier ahead of the PRACH long-sequence correlator. Phase accumulator
//   plus quarter-wave cosine ROM, one sample per in_valid, latency 4 cycles,
//   no backpressure.
//   Ports:
//     clk   clock, all logic on posedge
//     rst   synchronous active-high reset
//     bus   nco_twiddle_if.slave: cfg_pinc/cfg_poff/cfg_load/sync/in_valid in,
//           out_valid/out_cos/out_sin out
//   AMP must be below 2^(OUT_WIDTH-1); negating a table value then never
//   overflows, so the sign stage needs no saturation.
// -----------------------------------------------------------------------------
module nco_twiddle
    import nco_twiddle_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int LUT_AW      = LUT_AW_DEF,
    parameter int OUT_WIDTH   = 16,
    parameter int AMP         = AMP_DEF
) (
    input  logic           clk,
    input  logic           rst,
    nco_twiddle_if.slave   bus
);
    localparam int IDX_W = LUT_AW + 2;
    localparam int MAG_W = OUT_WIDTH - 1;

    function automatic logic signed [OUT_WIDTH-1:0] apply_sign(
        input logic [MAG_W-1:0] mag,
        input logic             neg
    );
        logic signed [OUT_WIDTH-1:0] ext;
        ext = $signed({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    // Control state
    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] shadow_pinc_q, shadow_poff_q;
    logic [PHASE_WIDTH-1:0] act_pinc_q, act_poff_q;
    logic [PHASE_WIDTH-1:0] act_pinc_d, act_poff_d;
    logic                   vld_p1_q, vld_p2_q, vld_p3_q;
    logic                   out_valid_q;
    logic signed [OUT_WIDTH-1:0] out_cos_q, out_sin_q;

    // Datapath state
    logic [PHASE_WIDTH-1:0] ph_d;
    logic [IDX_W-1:0]       idx_p1_q;
    quad_e                  quad_p2_q, quad_p3_q;
    logic [LUT_AW-1:0]      addr_p2_q, naddr_p2_q;
    logic [MAG_W-1:0]       mag_a_p3, mag_b_p3;
    logic signed [OUT_WIDTH-1:0] cos_d, sin_d;

    // ---- Stage 0: sync/load resolution, phase of this cycle, accumulator ----
    // A load coinciding with sync bypasses the shadow so the new settings
    // take effect on the very sample issued with the sync.
    always_comb begin
        act_pinc_d = act_pinc_q;
        act_poff_d = act_poff_q;
        if (bus.sync) begin
            act_pinc_d = bus.cfg_load ? bus.cfg_pinc : shadow_pinc_q;
            act_poff_d = bus.cfg_load ? bus.cfg_poff : shadow_poff_q;
        end

        ph_d = (bus.sync ? '0 : acc_q) + act_poff_d;

        acc_d = acc_q;
        if (bus.sync) begin
            acc_d = bus.in_valid ? act_pinc_d : '0;
        end else if (bus.in_valid) begin
            acc_d = acc_q + act_pinc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            shadow_pinc_q <= '0;
            shadow_poff_q <= '0;
            act_pinc_q    <= '0;
            act_poff_q    <= '0;
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            vld_p3_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_cos_q     <= '0;
            out_sin_q     <= '0;
        end else begin
            if (bus.cfg_load) begin
                shadow_pinc_q <= bus.cfg_pinc;
                shadow_poff_q <= bus.cfg_poff;
            end
            act_pinc_q  <= act_pinc_d;
            act_poff_q  <= act_poff_d;
            acc_q       <= acc_d;
            vld_p1_q    <= bus.in_valid;
            vld_p2_q    <= vld_p1_q;
            vld_p3_q    <= vld_p2_q;
            out_valid_q <= vld_p3_q;
            // Output holds the last sample while no new one arrives.
            if (vld_p3_q) begin
                out_cos_q <= cos_d;
                out_sin_q <= sin_d;
            end
        end
    end

    // ---- Stage 1: register the truncated table index of the phase ----
    // ---- Stage 2: split into quadrant, address and mirrored address ----
    always_ff @(posedge clk) begin
        idx_p1_q   <= IDX_W'(ph_d >> (PHASE_WIDTH - IDX_W));
        quad_p2_q  <= quad_e'(idx_p1_q[IDX_W-1 -: 2]);
        addr_p2_q  <= idx_p1_q[LUT_AW-1:0];
        naddr_p2_q <= ~idx_p1_q[LUT_AW-1:0];
        quad_p3_q  <= quad_p2_q;
    end

    // ---- Stage 3: registered dual read, port A = C[i], port B = C[~i] ----
    nco_twiddle_rom #(
        .LUT_AW    (LUT_AW),
        .OUT_WIDTH (OUT_WIDTH),
        .AMP       (AMP)
    ) u_rom (
        .clk      (clk),
        .addr_a_i (addr_p2_q),
        .addr_b_i (naddr_p2_q),
        .data_a_o (mag_a_p3),
        .data_b_o (mag_b_p3)
    );

    // ---- Stage 4: quadrant swap and sign, loaded into the output regs ----
    always_comb begin
        cos_d = '0;
        sin_d = '0;
        case (quad_p3_q)
            Q0: begin
                cos_d = apply_sign(mag_a_p3, 1'b0);
                sin_d = apply_sign(mag_b_p3, 1'b0);
            end
            Q1: begin
                cos_d = apply_sign(mag_b_p3, 1'b1);
                sin_d = apply_sign(mag_a_p3, 1'b0);
            end
            Q2: begin
                cos_d = apply_sign(mag_a_p3, 1'b1);
                sin_d = apply_sign(mag_b_p3, 1'b1);
            end
            Q3: begin
                cos_d = apply_sign(mag_b_p3, 1'b0);
                sin_d = apply_sign(mag_a_p3, 1'b1);
            end
            default: begin
                cos_d = '0;
                sin_d = '0;
            end
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_cos   = out_cos_q;
    assign bus.out_sin   = out_sin_q;

endmodule

// File: tb/tb_nco_twiddle.sv
module tb_nco_twiddle;

    localparam int PW   = 24;
    localparam int LAW  = 10;
    localparam int OW   = 16;
    localparam int AMPV = 16383;

    localparam logic [PW-1:0] P22 = PW'(1 << 22);
    localparam logic [PW-1:0] P23 = PW'(1 << 23);
    localparam logic [PW-1:0] Z   = '0;

    // Hand-computed table ends: C[0] = 16383, C[1023] = 13
    localparam int AC = 16383;
    localparam int AS = 13;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nco_twiddle_if #(.PHASE_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

    nco_twiddle #(
        .PHASE_WIDTH (PW),
        .LUT_AW      (LAW),
        .OUT_WIDTH   (OW),
        .AMP         (AMPV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          rst;
        logic          ld;
        logic          sy;
        logic          iv;
        logic [PW-1:0] pinc;
        logic [PW-1:0] poff;
        logic          ev;
        int            ec;
        int            es;
    } vec_t;

    typedef struct {
        logic ev;
        int   ec;
        int   es;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic ld, input logic sy, input logic iv,
                       input logic [PW-1:0] pinc, input logic [PW-1:0] poff,
                       input logic ev, input int ec, input int es);
        vec_t v;
        v.rst = r; v.ld = ld; v.sy = sy; v.iv = iv;
        v.pinc = pinc; v.poff = poff;
        v.ev = ev; v.ec = ec; v.es = es;
        vecs.push_back(v);
    endtask

    task automatic vld(input logic ev, input int ec, input int es);
        add(1'b0, 1'b0, 1'b0, 1'b1, Z, Z, ev, ec, es);
    endtask

    task automatic idle(input logic ev, input int ec, input int es);
        add(1'b0, 1'b0, 1'b0, 1'b0, Z, Z, ev, ec, es);
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic apply(input logic r, input logic ld, input logic sy, input logic iv,
                         input logic [PW-1:0] pinc, input logic [PW-1:0] poff);
        rst          = r;
        bus.cfg_load = ld;
        bus.sync     = sy;
        bus.in_valid = iv;
        bus.cfg_pinc = pinc;
        bus.cfg_poff = poff;
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // Real-valued reference: truncated index, angle at the bin centre.
    task automatic model(input logic [PW-1:0] ph, output int c, output int s);
        int  p;
        real th;
        p  = int'(ph >> (PW - LAW - 2));
        th = 2.0 * 3.14159265358979323846 * ($itor(p) + 0.5) / $itor(4 << LAW);
        c  = rnd($itor(AMPV) * $cos(th));
        s  = rnd($itor(AMPV) * $sin(th));
    endtask

    initial begin
        rst          = 1'b1;
        bus.cfg_load = 1'b0;
        bus.sync     = 1'b0;
        bus.in_valid = 1'b0;
        bus.cfg_pinc = '0;
        bus.cfg_poff = '0;

        // 1: reset, zero pinc/poff, eight samples of angle zero
        add(1, 0, 0, 0, Z, Z, 0, 0, 0);
        add(1, 0, 0, 0, Z, Z, 0, 0, 0);
        add(0, 1, 0, 0, Z, Z, 0, 0, 0);
        add(0, 0, 1, 0, Z, Z, 0, 0, 0);
        for (int k = 0; k < 3; k++) vld(0, 0, 0);
        for (int k = 0; k < 5; k++) vld(1, AC, AS);
        for (int k = 0; k < 3; k++) idle(1, AC, AS);
        idle(0, AC, AS);
        // 2: quarter-turn steps through all four quadrants
        add(0, 1, 0, 0, P22, Z, 0, AC, AS);
        add(0, 0, 1, 0, Z, Z, 0, AC, AS);
        for (int k = 0; k < 3; k++) vld(0, AC, AS);
        vld(1, AC, AS);
        vld(1, -AS, AC);
        vld(1, -AC, -AS);
        vld(1, AS, -AC);
        vld(1, AC, AS);
        // 3: load without sync leaves the sequence alone; sync switches to half-turns
        add(0, 1, 0, 1, P23, Z, 1, -AS, AC);
        vld(1, -AC, -AS);
        vld(1, AS, -AC);
        add(0, 0, 1, 1, Z, Z, 1, AC, AS);
        vld(1, -AS, AC);
        vld(1, -AC, -AS);
        vld(1, AC, AS);
        vld(1, -AC, -AS);
        idle(1, AC, AS);
        idle(1, -AC, -AS);
        idle(1, AC, AS);
        idle(0, AC, AS);
        // 4: load together with sync takes the new offset immediately
        add(0, 1, 1, 0, Z, P23, 0, AC, AS);
        for (int k = 0; k < 3; k++) vld(0, AC, AS);
        vld(1, -AC, -AS);
        for (int k = 0; k < 3; k++) idle(1, -AC, -AS);
        idle(0, -AC, -AS);
        // 5: gapped in_valid, phase advances only on valid samples
        add(0, 1, 1, 0, P22, Z, 0, -AC, -AS);
        vld(0, -AC, -AS);
        idle(0, -AC, -AS);
        idle(0, -AC, -AS);
        vld(1, AC, AS);
        vld(0, AC, AS);
        idle(0, AC, AS);
        idle(1, -AS, AC);
        idle(1, -AC, -AS);
        idle(0, -AC, -AS);
        // 6: one-cycle reset mid-stream drops in-flight samples and restarts phase
        vld(0, -AC, -AS);
        vld(0, -AC, -AS);
        add(1, 0, 0, 1, Z, Z, 0, 0, 0);
        for (int k = 0; k < 3; k++) vld(0, 0, 0);
        for (int k = 0; k < 3; k++) idle(1, AC, AS);
        idle(0, AC, AS);

        for (int r = 0; r < vecs.size(); r++) begin
            apply(vecs[r].rst, vecs[r].ld, vecs[r].sy, vecs[r].iv, vecs[r].pinc, vecs[r].poff);
            checks++;
            if (bus.out_valid !== vecs[r].ev || int'(bus.out_cos) !== vecs[r].ec ||
                int'(bus.out_sin) !== vecs[r].es) begin
                errors++;
                $display("FAIL row%0d: got valid=%0b cos=%0d sin=%0d, want valid=%0b cos=%0d sin=%0d",
                         r, bus.out_valid, int'(bus.out_cos), int'(bus.out_sin),
                         vecs[r].ev, vecs[r].ec, vecs[r].es);
            end
        end

        // Random pinc/poff against the real-valued model. The last three
        // table rows issued no sample, so the expected pipe starts empty.
        for (int k = 0; k < 3; k++) expq.push_back('{1'b0, 0, 0});
        for (int cfg = 0; cfg < 3; cfg++) begin
            logic [PW-1:0] pinc, poff, acc;
            pinc = PW'($urandom());
            poff = PW'($urandom());
            acc  = '0;
            for (int n = 0; n < 66; n++) begin
                logic iv, ld, sy;
                exp_t e;
                ld = (n == 0);
                sy = (n == 0);
                iv = (n > 0 && n < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
                e.ev = iv; e.ec = 0; e.es = 0;
                if (iv) begin
                    model(acc + poff, e.ec, e.es);
                    acc = acc + pinc;
                end
                expq.push_back(e);
                apply(1'b0, ld, sy, iv, pinc, poff);
                e = expq.pop_front();
                checks++;
                if (bus.out_valid !== e.ev ||
                    (e.ev && (int'(bus.out_cos) !== e.ec || int'(bus.out_sin) !== e.es))) begin
                    errors++;
                    $display("FAIL rand%0d.%0d: got valid=%0b cos=%0d sin=%0d, want valid=%0b cos=%0d sin=%0d",
                             cfg, n, bus.out_valid, int'(bus.out_cos), int'(bus.out_sin),
                             e.ev, e.ec, e.es);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
